ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 136 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with per-key held/press tracking.
// Decodes E0/F0 prefixes and matches up to NUM_KEYS configured scan codes.
module ps2_key_tracker #(
    parameter int                     NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]  KEY_CODES      = {9'h174, 9'h172, 9'h16B, 9'h175},
    parameter int                     SYNC_STAGES    = 2,
    parameter int                     TIMEOUT_CYCLES = 50000
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                PS2Clock,
    input  logic                PS2Data,
    output logic [NUM_KEYS-1:0] KeyHeld,
    output logic [NUM_KEYS-1:0] KeyPress,
    output logic [7:0]          ScanCode,
    output logic                ScanValid,
    output logic                Extended,
    output logic                Release,
    output logic                FrameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   ps2c_prev;
    logic [2:0]             bitcnt;
    logic [7:0]             shift;
    logic                   par_err;
    logic [TW-1:0]          tocnt;
    logic                   pend_ext, pend_rel;
    logic                   falling, sdat;
    logic [NUM_KEYS-1:0]    match;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            ps2c_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2Clock};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], PS2Data};
            ps2c_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign falling = ps2c_prev & ~clk_sync[SYNC_STAGES-1];
    assign sdat    = dat_sync[SYNC_STAGES-1];

    // Key match is evaluated on the assembled byte while the stop bit arrives.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            match[i] = (shift == KEY_CODES[9*i +: 8]) && (pend_ext == KEY_CODES[9*i+8]);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            tocnt      <= '0;
            pend_ext   <= 1'b0;
            pend_rel   <= 1'b0;
            KeyHeld    <= '0;
            KeyPress   <= '0;
            ScanCode   <= '0;
            ScanValid  <= 1'b0;
            Extended   <= 1'b0;
            Release    <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            ScanValid  <= 1'b0;
            KeyPress   <= '0;
            FrameError <= 1'b0;
            if (state == IDLE) begin
                tocnt <= '0;
                if (falling && !sdat) begin
                    state  <= DATA;
                    bitcnt <= '0;
                end
            end else if (falling) begin
                tocnt <= '0;
                case (state)
                    DATA: begin
                        shift  <= {sdat, shift[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_err <= ~(^shift ^ sdat);
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!sdat || par_err) begin
                            FrameError <= 1'b1;
                            pend_ext   <= 1'b0;
                            pend_rel   <= 1'b0;
                        end else if (shift == 8'hE0) begin
                            pend_ext <= 1'b1;
                        end else if (shift == 8'hF0) begin
                            pend_rel <= 1'b1;
                        end else begin
                            ScanCode  <= shift;
                            Extended  <= pend_ext;
                            Release   <= pend_rel;
                            ScanValid <= 1'b1;
                            pend_ext  <= 1'b0;
                            pend_rel  <= 1'b0;
                            for (int i = 0; i < NUM_KEYS; i++) begin
                                if (match[i]) begin
                                    KeyHeld[i]  <= ~pend_rel;
                                    KeyPress[i] <= ~pend_rel & ~KeyHeld[i];
                                end
                            end
                        end
                    end
                endcase
            end else if (tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state      <= IDLE;
                tocnt      <= '0;
                FrameError <= 1'b1;
                pend_ext   <= 1'b0;
                pend_rel   <= 1'b0;
            end else begin
                tocnt <= tocnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Drives PS/2 frames (directed + random) and compares against a byte-level key model.
module tb_ps2_key_tracker;

    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1, ps2d = 1'b1;
    logic [3:0] KeyHeld, KeyPress;
    logic [7:0] ScanCode;
    logic       ScanValid, Extended, Release, FrameError;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock(clk), .Reset(rst), .PS2Clock(ps2c), .PS2Data(ps2d),
        .KeyHeld(KeyHeld), .KeyPress(KeyPress), .ScanCode(ScanCode),
        .ScanValid(ScanValid), .Extended(Extended), .Release(Release),
        .FrameError(FrameError)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor
    int         sv_cnt = 0, fe_cnt = 0, kp_cyc = 0;
    logic [7:0] sv_code = '0;
    logic       sv_ext = 1'b0, sv_rel = 1'b0;
    logic [3:0] kp_last = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ScanValid) begin
                sv_cnt  <= sv_cnt + 1;
                sv_code <= ScanCode;
                sv_ext  <= Extended;
                sv_rel  <= Release;
            end
            if (FrameError) fe_cnt <= fe_cnt + 1;
            if (KeyPress != 0) begin
                kp_cyc  <= kp_cyc + 1;
                kp_last <= KeyPress;
            end
        end
    end

    // Reference model: configured keys as {E0 flag, make code}
    logic [8:0] keytab [4] = '{9'h175, 9'h16B, 9'h172, 9'h174};
    logic [3:0] m_held = '0;
    bit         m_e = 0, m_f = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit badpar, input bit badstop);
        return {~badstop, (~^b) ^ badpar, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            cyc(10);
            ps2c = 1'b0;
            cyc(20);
            ps2c = 1'b1;
            cyc(10);
        end
    endtask

    task automatic check_frame(input int s0, input int f0, input int k0,
                               input bit exp_sv, input bit exp_fe, input logic [7:0] b,
                               input bit ee, input bit ef, input logic [3:0] exp_kp);
        chk("scanvalid_cnt", sv_cnt - s0, exp_sv);
        chk("frameerr_cnt", fe_cnt - f0, exp_fe);
        chk("keypress_cyc", kp_cyc - k0, exp_kp != 0);
        chk("keyheld", KeyHeld, m_held);
        if (exp_sv) chk("scan_code_ext_rel", {sv_code, sv_ext, sv_rel}, {b, ee, ef});
        if (exp_kp != 0) chk("keypress_mask", kp_last, exp_kp);
    endtask

    task automatic do_byte(input logic [7:0] b, input bit badpar, input bit badstop);
        int s0, f0, k0;
        bit exp_sv, exp_fe, ee, ef;
        logic [3:0] exp_kp;
        s0 = sv_cnt; f0 = fe_cnt; k0 = kp_cyc;
        send_bits(frame(b, badpar, badstop), 11);
        ps2d = 1'b1;
        cyc(20);
        exp_sv = 0; exp_fe = 0; exp_kp = '0; ee = m_e; ef = m_f;
        if (badpar || badstop) begin
            exp_fe = 1; m_e = 0; m_f = 0;
        end else if (b == 8'hE0) begin
            m_e = 1;
        end else if (b == 8'hF0) begin
            m_f = 1;
        end else begin
            exp_sv = 1;
            for (int i = 0; i < 4; i++) begin
                if (keytab[i] == {m_e, b}) begin
                    if (m_f) m_held[i] = 1'b0;
                    else begin
                        if (!m_held[i]) exp_kp[i] = 1'b1;
                        m_held[i] = 1'b1;
                    end
                end
            end
            m_e = 0; m_f = 0;
        end
        check_frame(s0, f0, k0, exp_sv, exp_fe, b, ee, ef, exp_kp);
    endtask

    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1C, 8'h00};

    initial begin
        int s0, f0, k0;
        logic [7:0] b;
        cyc(3);
        chk("reset_outputs", {KeyHeld, KeyPress, ScanCode, ScanValid, Extended, Release, FrameError}, 0);
        rst = 1'b0;
        cyc(5);

        // Press, typematic repeats, release
        repeat (3) begin
            do_byte(8'hE0, 0, 0);
            do_byte(8'h75, 0, 0);
        end
        do_byte(8'hE0, 0, 0); do_byte(8'hF0, 0, 0); do_byte(8'h75, 0, 0);
        do_byte(8'h75, 1, 0);
        do_byte(8'hE0, 0, 0); do_byte(8'h6B, 0, 0);

        // Partial frame abandoned by timeout
        s0 = sv_cnt; f0 = fe_cnt; k0 = kp_cyc;
        send_bits(frame(8'h75, 0, 0), 5);
        ps2d = 1'b1;
        cyc(TO + 100);
        m_e = 0; m_f = 0;
        check_frame(s0, f0, k0, 0, 1, 8'h00, 0, 0, 4'h0);
        do_byte(8'h1C, 0, 0);

        // Build KeyHeld = 1001, then reset mid-frame
        do_byte(8'hE0, 0, 0); do_byte(8'h75, 0, 0);
        do_byte(8'hE0, 0, 0); do_byte(8'h74, 0, 0);
        do_byte(8'hE0, 0, 0); do_byte(8'hF0, 0, 0); do_byte(8'h6B, 0, 0);
        chk("held_before_reset", KeyHeld, 4'b1001);
        send_bits(frame(8'h1C, 0, 0), 5);
        ps2d = 1'b0;
        cyc(10);
        ps2c = 1'b0;
        cyc(5);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", {KeyHeld, KeyPress, ScanCode, ScanValid, Extended, Release, FrameError}, 0);
        cyc(3);
        ps2c = 1'b1; ps2d = 1'b1;
        cyc(3);
        rst = 1'b0;
        m_held = '0; m_e = 0; m_f = 0;
        cyc(5);
        do_byte(8'hE0, 0, 0); do_byte(8'h74, 0, 0);
        chk("held_after_reset", KeyHeld, 4'b1000);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom);
            do_byte(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
